// File: rtl/id_regfile_datapath.sv
// Decode-stage datapath: 32-entry register file with write-through reads,
// immediate sign extension and destination select, all captured into the ID/EX outputs.
module id_regfile_datapath #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_flag,
  input  logic [ADDR_W-1:0] inst_read_reg_addr1,
  input  logic [ADDR_W-1:0] inst_read_reg_addr2,
  input  logic [ADDR_W-1:0] rd,
  input  logic              reg_dst,
  input  logic [IMM_W-1:0]  inst_imm_field,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] reg_wr_addr_wb,
  input  logic [DATA_W-1:0] reg_wr_data,
  output logic [DATA_W-1:0] reg_file_rd_data1,
  output logic [DATA_W-1:0] reg_file_rd_data2,
  output logic [DATA_W-1:0] sgn_ext_imm,
  output logic [DATA_W-1:0] imm_sgn_ext_lft_shft,
  output logic [ADDR_W-1:0] reg_wr_addr
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] rd_val1, rd_val2, sext_val, shft_val;
  logic              wr_en;

  assign wr_en = reg_write && (reg_wr_addr_wb != '0);

  // NOTE: the register array is reset explicitly because the interface promises every
  // register reads 0 after reset; an unreset memory would leave X in simulation and silicon.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values, matching hardware.
      regs[reg_wr_addr_wb] <= reg_wr_data;
    end
  end

  // Write-through bypass: a read that hits this edge's writeback sees the new data.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned and infers a latch.
    rd_val1 = regs[inst_read_reg_addr1];
    rd_val2 = regs[inst_read_reg_addr2];
    if (wr_en && reg_wr_addr_wb == inst_read_reg_addr1) rd_val1 = reg_wr_data;
    if (wr_en && reg_wr_addr_wb == inst_read_reg_addr2) rd_val2 = reg_wr_data;
    if (inst_read_reg_addr1 == '0) rd_val1 = '0;
    if (inst_read_reg_addr2 == '0) rd_val2 = '0;
  end

  assign sext_val = {{(DATA_W-IMM_W){inst_imm_field[IMM_W-1]}}, inst_imm_field};
  assign shft_val = {sext_val[DATA_W-3:0], 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_file_rd_data1    <= '0;
      reg_file_rd_data2    <= '0;
      sgn_ext_imm          <= '0;
      imm_sgn_ext_lft_shft <= '0;
      reg_wr_addr          <= '0;
    end else if (!stall_flag) begin
      reg_file_rd_data1    <= rd_val1;
      reg_file_rd_data2    <= rd_val2;
      sgn_ext_imm          <= sext_val;
      imm_sgn_ext_lft_shft <= shft_val;
      reg_wr_addr          <= reg_dst ? rd : inst_read_reg_addr2;
    end
  end

endmodule

// File: tb/tb_id_regfile_datapath.sv
// Scoreboard bench for id_regfile_datapath: stimulus pushes model predictions,
// a monitor pops one prediction per clock and compares it with the registered outputs.
module tb_id_regfile_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_flag;
  logic [4:0]  inst_read_reg_addr1, inst_read_reg_addr2, rd, reg_wr_addr_wb;
  logic        reg_dst, reg_write;
  logic [15:0] inst_imm_field;
  logic [31:0] reg_wr_data;
  logic [31:0] reg_file_rd_data1, reg_file_rd_data2, sgn_ext_imm, imm_sgn_ext_lft_shft;
  logic [4:0]  reg_wr_addr;

  id_regfile_datapath dut (
    .clk                  (clk),
    .reset                (reset),
    .stall_flag           (stall_flag),
    .inst_read_reg_addr1  (inst_read_reg_addr1),
    .inst_read_reg_addr2  (inst_read_reg_addr2),
    .rd                   (rd),
    .reg_dst              (reg_dst),
    .inst_imm_field       (inst_imm_field),
    .reg_write            (reg_write),
    .reg_wr_addr_wb       (reg_wr_addr_wb),
    .reg_wr_data          (reg_wr_data),
    .reg_file_rd_data1    (reg_file_rd_data1),
    .reg_file_rd_data2    (reg_file_rd_data2),
    .sgn_ext_imm          (sgn_ext_imm),
    .imm_sgn_ext_lft_shft (imm_sgn_ext_lft_shft),
    .reg_wr_addr          (reg_wr_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d1, d2, se, sh;
    logic [4:0]  wa;
  } exp_t;

  exp_t        sb_q [$];
  exp_t        held;
  logic [31:0] m_regs [32];
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference read: architectural register value, or same-edge writeback data.
  function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (a == 0) return 32'h0;
    if (we && wa == a) return wd;
    return m_regs[a];
  endfunction

  task automatic drive(input logic st, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] rdf, input logic dst, input logic [15:0] imm,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    int signed sx;
    @(negedge clk);
    stall_flag = st; inst_read_reg_addr1 = a1; inst_read_reg_addr2 = a2; rd = rdf;
    reg_dst = dst; inst_imm_field = imm; reg_write = we; reg_wr_addr_wb = wa; reg_wr_data = wd;
    if (!st) begin
      sx      = int'($signed(imm));
      held.d1 = model_read(a1, we, wa, wd);
      held.d2 = model_read(a2, we, wa, wd);
      held.se = 32'(sx);
      held.sh = 32'(sx * 4);
      held.wa = dst ? rdf : a2;
    end
    sb_q.push_back(held);
    if (we && wa != 0) m_regs[wa] = wd;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_d1"}, reg_file_rd_data1, 32'h0);
    check({tag, "_d2"}, reg_file_rd_data2, 32'h0);
    check({tag, "_se"}, sgn_ext_imm, 32'h0);
    check({tag, "_sh"}, imm_sgn_ext_lft_shft, 32'h0);
    check({tag, "_wa"}, {27'h0, reg_wr_addr}, 32'h0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin @(posedge clk); #2; n++; end
    check("scoreboard_drain", sb_q.size(), 0);
  endtask

  // Reset in the middle of operation with a write pending: it must not land.
  task automatic mid_reset();
    wait_drain();
    @(negedge clk);
    reset = 1'b1; reg_write = 1'b1; reg_wr_addr_wb = 5'd5; reg_wr_data = 32'h5555_AAAA;
    stall_flag = 1'b0; inst_read_reg_addr1 = 5'd5;
    #1 check_zero_outputs("async_reset");
    @(posedge clk); #1 check_zero_outputs("reset_held");
    @(negedge clk);
    reg_write = 1'b0; reset = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    held = '{default: '0};
  endtask

  // Monitor: every clock is an output presentation while stimulus is queued.
  initial begin
    forever begin
      exp_t e;
      @(posedge clk); #1;
      if (!reset && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("rd_data1", reg_file_rd_data1, e.d1);
        check("rd_data2", reg_file_rd_data2, e.d2);
        check("sgn_ext_imm", sgn_ext_imm, e.se);
        check("imm_shift", imm_sgn_ext_lft_shft, e.sh);
        check("reg_wr_addr", {27'h0, reg_wr_addr}, {27'h0, e.wa});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall_flag = 1'b0; inst_read_reg_addr1 = 5'd0; inst_read_reg_addr2 = 5'd0;
    rd = 5'd0; reg_dst = 1'b0; inst_imm_field = 16'h0; reg_write = 1'b0;
    reg_wr_addr_wb = 5'd0; reg_wr_data = 32'h0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    held = '{default: '0};
    #12 check_zero_outputs("reset");
    @(negedge clk); reset = 1'b0;

    // Every register reads 0 after reset
    for (int i = 0; i < 32; i++)
      drive(0, 5'(i), 5'(31 - i), 5'd0, 0, 16'h0, 0, 5'd0, 32'h0);

    // Write then read from both ports; r0 write ignored; same-edge bypass
    drive(0, 5'd0, 5'd0, 5'd0, 0, 16'h0, 1, 5'd5, 32'hDEAD_BEEF);
    drive(0, 5'd5, 5'd5, 5'd0, 0, 16'h0, 1, 5'd0, 32'h0000_1234);
    drive(0, 5'd0, 5'd0, 5'd0, 0, 16'h0, 0, 5'd0, 32'h0);
    drive(0, 5'd7, 5'd0, 5'd0, 0, 16'h0, 1, 5'd7, 32'hA5A5_A5A5);
    drive(0, 5'd0, 5'd0, 5'd0, 0, 16'h0, 1, 5'd0, 32'hFFFF_FFFF);

    // Immediate boundaries and destination select
    drive(0, 5'd5, 5'd7, 5'd0, 0, 16'h8001, 0, 5'd0, 32'h0);
    drive(0, 5'd5, 5'd7, 5'd0, 0, 16'h7FFF, 0, 5'd0, 32'h0);
    drive(0, 5'd1, 5'd3, 5'd9, 0, 16'hFFFF, 0, 5'd0, 32'h0);
    drive(0, 5'd1, 5'd3, 5'd9, 1, 16'h0000, 0, 5'd0, 32'h0);

    // Stall with all inputs changing and a write to r12, then release and read it
    drive(1, 5'd12, 5'd12, 5'd30, 1, 16'hC000, 1, 5'd12, 32'h1357_9BDF);
    drive(1, 5'd5, 5'd12, 5'd17, 0, 16'h4000, 0, 5'd0, 32'h0);
    drive(0, 5'd12, 5'd5, 5'd17, 1, 16'h4000, 0, 5'd0, 32'h0);

    // Randomized traffic with stalls, writes and frequent bypass hits
    for (int n = 0; n < 400; n++) begin
      logic [4:0] a1, a2, wa;
      a1 = 5'($urandom_range(0, 31));
      a2 = 5'($urandom_range(0, 31));
      wa = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 4) == 0), a1, a2, 5'($urandom_range(0, 31)),
            1'($urandom), 16'($urandom), 1'($urandom), wa, $urandom);
    end

    mid_reset();
    drive(0, 5'd5, 5'd12, 5'd0, 0, 16'h0, 0, 5'd0, 32'h0);
    for (int n = 0; n < 40; n++)
      drive(1'($urandom_range(0, 3) == 0), 5'($urandom), 5'($urandom), 5'($urandom),
            1'($urandom), 16'($urandom), 1'($urandom), 5'($urandom), $urandom);

    wait_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
